counter_step_arbiter: RTL and testbench

Controller in front of the 4-bit up/down counter in the VGA monitor design. It shares the counter between two requesters, for example cursor/position step sources. It accepts step requests with a direction, arbitrates round-robin, and drives the counter's `enable` and `forward` inputs as single-cycle step pulses. It reads the counter's output back to enforce saturation limits and grants one step per arbitration.

---
 rtl/counter_ctrl_defs.sv | 19 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/counter_step_arbiter.sv | 119 +++++++++++
 tb/tb_counter_step_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_defs.sv
// Shared definitions for the counter step controller: FSM state
// encodings, direction constants and a small grant decoding helper.
package counter_ctrl_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Index of the requester selected by a one-hot two-bit grant vector.
  function automatic logic grant_idx(input logic [1:0] g);
    return (g == 2'b10);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. A lone request always wins; on a tie the
// requester that was not served last wins. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Pick the winner from the active requests and the last-served pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/counter_step_arbiter.sv
// Shares the up/down counter between two step requesters. Each accepted
// request produces a one-cycle step pulse on cnt_enable (or an at_limit
// pulse when the step would cross a bound), followed by a settle window.
module counter_step_arbiter
  import counter_ctrl_defs::*;
#(
  parameter int WIDTH         = 4,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 15,
  parameter int WRAP          = 0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       dir,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_enable,
  output logic             cnt_forward,
  output logic [1:0]       grant,
  output logic             at_limit,
  output logic             busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_L       = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_L       = WIDTH'(MAX_VAL);

  state_t        state_q;
  logic          last_q;
  logic [SW-1:0] settle_q;
  logic          cnt_enable_q;
  logic          cnt_forward_q;
  logic [1:0]    grant_q;
  logic          at_limit_q;
  logic          busy_q;

  logic [1:0]    win_d;
  logic          win_idx_d;
  logic          dir_w_d;
  logic          blocked_d;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (win_d)
  );

  // Direction of the winner and whether its step would cross a bound
  always_comb begin
    win_idx_d = grant_idx(win_d);
    dir_w_d   = win_idx_d ? dir[1] : dir[0];
    blocked_d = 1'b0;
    if (WRAP == 0) begin
      if (dir_w_d == DIR_UP)
        blocked_d = (count_in == MAX_L);
      else if (dir_w_d == DIR_DOWN)
        blocked_d = (count_in == MIN_L);
    end
  end

  // Step FSM with registered outputs; reset abandons any in-flight step
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_q        <= 1'b1;
      settle_q      <= '0;
      cnt_enable_q  <= 1'b0;
      cnt_forward_q <= 1'b0;
      grant_q       <= 2'b00;
      at_limit_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q       <= ST_ISSUE;
            busy_q        <= 1'b1;
            last_q        <= win_idx_d;
            grant_q       <= win_d;
            cnt_forward_q <= dir_w_d;
            cnt_enable_q  <= !blocked_d;
            at_limit_q    <= blocked_d;
          end
        end
        ST_ISSUE: begin
          state_q      <= ST_SETTLE;
          settle_q     <= SETTLE_LOAD;
          grant_q      <= 2'b00;
          cnt_enable_q <= 1'b0;
          at_limit_q   <= 1'b0;
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          grant_q      <= 2'b00;
          cnt_enable_q <= 1'b0;
          at_limit_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_enable  = cnt_enable_q;
  assign cnt_forward = cnt_forward_q;
  assign grant       = grant_q;
  assign at_limit    = at_limit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_counter_step_arbiter.sv
// Directed bench for counter_step_arbiter: a saturating instance and a
// wrapping instance driven by the same stimulus.
module tb_counter_step_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] dir;
  logic [3:0] count_in;

  logic       cnt_enable, cnt_forward, at_limit, busy;
  logic [1:0] grant;
  logic       cnt_enable_w, cnt_forward_w, at_limit_w, busy_w;
  logic [1:0] grant_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_step_arbiter #(
    .WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .WRAP(0), .SETTLE_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .dir(dir), .count_in(count_in),
    .cnt_enable(cnt_enable), .cnt_forward(cnt_forward), .grant(grant),
    .at_limit(at_limit), .busy(busy)
  );

  counter_step_arbiter #(
    .WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .WRAP(1), .SETTLE_CYCLES(1)
  ) dut_w (
    .clk(clk), .reset(reset), .req(req), .dir(dir), .count_in(count_in),
    .cnt_enable(cnt_enable_w), .cnt_forward(cnt_forward_w), .grant(grant_w),
    .at_limit(at_limit_w), .busy(busy_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || busy_w) && n < 8) begin
      tick();
      n++;
    end
    check(tag, {30'd0, busy, busy_w}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; req = 2'b11; dir = 2'b00; count_in = 4'd8;

    // 1: reset with both requests pending
    tick(); tick();
    check("rst_outs", {grant, cnt_enable, cnt_forward, at_limit, busy}, 32'd0);
    check("rst_outs_w", {grant_w, cnt_enable_w, cnt_forward_w, at_limit_w, busy_w}, 32'd0);
    reset = 1'b1;
    tick();
    check("rst_first_grant", grant, 32'h1);
    check("rst_first_busy", busy, 32'h1);
    req = 2'b00;
    wait_idle("rst_idle");

    // 2: single step up, dir changes after sampling must not matter
    req = 2'b01; dir = 2'b01; count_in = 4'd3;
    tick();
    check("up_pulse", {grant, cnt_enable, cnt_forward, at_limit, busy}, 32'b01_1_1_0_1);
    req = 2'b00; dir = 2'b00;
    tick();
    check("up_settle", {grant, cnt_enable, cnt_forward, at_limit, busy}, 32'b00_0_1_0_1);
    tick();
    check("up_idle_busy", busy, 32'h0);
    tick();
    check("up_no_regrant", grant, 32'h0);

    // 3: contention from reset pointer, grants alternate every 3 cycles
    reset = 1'b0;
    tick();
    reset = 1'b1;
    req = 2'b11; dir = 2'b01; count_in = 4'd8;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rr_grant%0d", i), grant, (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr_fwd%0d", i), {cnt_enable, cnt_forward}, (i % 2 == 0) ? 32'h3 : 32'h2);
      tick();
      check($sformatf("rr_gap%0d", i), {grant, cnt_enable}, 32'h0);
      tick();
      check($sformatf("rr_idle%0d", i), busy, 32'h0);
    end
    req = 2'b00;
    tick();
    check("rr_withdrawn", {grant, busy}, 32'h0);

    // 4: upper bound, saturating vs wrapping
    req = 2'b01; dir = 2'b01; count_in = 4'd15;
    tick();
    check("max_sat", {grant, cnt_enable, at_limit}, 32'b01_0_1);
    check("max_wrap", {grant_w, cnt_enable_w, at_limit_w}, 32'b01_1_0);
    req = 2'b00;
    tick();
    check("max_sat_clear", {at_limit, at_limit_w}, 32'h0);
    wait_idle("max_idle");

    // 5: lower bound, then one above it
    req = 2'b10; dir = 2'b00; count_in = 4'd0;
    tick();
    check("min_sat", {grant, cnt_enable, cnt_forward, at_limit}, 32'b10_0_0_1);
    check("min_wrap", {grant_w, cnt_enable_w, at_limit_w}, 32'b10_1_0);
    req = 2'b00;
    wait_idle("min_idle");
    req = 2'b10; count_in = 4'd1;
    tick();
    check("min_plus1", {grant, cnt_enable, cnt_forward, at_limit}, 32'b10_1_0_0);
    req = 2'b00;
    wait_idle("min_plus1_idle");

    // 6: reset during ISSUE abandons the step
    req = 2'b01; dir = 2'b01; count_in = 4'd5;
    tick();
    check("mid_issue", grant, 32'h1);
    reset = 1'b0;
    tick();
    check("mid_rst_outs", {grant, cnt_enable, cnt_forward, at_limit, busy}, 32'd0);
    reset = 1'b1; req = 2'b10; dir = 2'b00;
    tick();
    check("mid_rel_grant", {grant, cnt_enable, cnt_forward}, 32'b10_1_0);
    req = 2'b00;
    wait_idle("mid_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
